// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EX/MEM/WB from a latched
// instruction word, with a bus-wait timeout, illegal-opcode trap and instret counter.
module mc_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter bit EN_JUMP     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instrCode,
  input  logic             instr_valid,
  input  logic             bus_ready,
  output logic             pcEn,
  output logic             irEn,
  output logic             regFileWe,
  output logic [3:0]       aluControl,
  output logic             alu_src_mux_sel,
  output logic             busWe,
  output logic             busRe,
  output logic [2:0]       rf_wd_src_mux_sel,
  output logic [2:0]       mem_size,
  output logic             branch,
  output logic [1:0]       jump,
  output logic             illegal_instr,
  output logic             bus_error,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EX, MEM_S, MEM_L, WB_L, TRAP
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  state_t            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              bus_error_q, bus_error_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_lui, is_auipc, is_br, is_jal, is_jalr, is_load, is_store;
  logic       legal, timeout_hit, retire;
  logic       unused_ir_bits;

  assign opcode   = ir_q[6:0];
  assign funct3   = ir_q[14:12];
  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign is_br    = (opcode == OP_B);
  assign is_jal   = (opcode == OP_JAL) && EN_JUMP;
  assign is_jalr  = (opcode == OP_JALR) && EN_JUMP;
  assign is_load  = (opcode == OP_L);
  assign is_store = (opcode == OP_S);
  assign legal    = is_r | is_i | is_lui | is_auipc | is_br | is_jal | is_jalr | is_load | is_store;

  // The wait counter holds the number of elapsed ready-less MEM cycles before this one.
  assign timeout_hit = (MEM_TIMEOUT != 0) && !bus_ready && (wait_q == WAIT_LAST);

  // Register and immediate fields belong to the datapath, not to control.
  assign unused_ir_bits = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    wait_d      = wait_q;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    retire      = 1'b0;
    case (state_q)
      FETCH: begin
        if (instr_valid) begin
          ir_d    = instrCode;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (legal) begin
          state_d = EX;
        end else begin
          state_d   = TRAP;
          illegal_d = 1'b1;
        end
      end
      EX: begin
        wait_d = '0;
        if (is_store) begin
          state_d = MEM_S;
        end else if (is_load) begin
          state_d = MEM_L;
        end else begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      MEM_S, MEM_L: begin
        if (bus_ready) begin
          state_d = (state_q == MEM_S) ? FETCH : WB_L;
          retire  = (state_q == MEM_S);
        end else if (timeout_hit) begin
          state_d     = TRAP;
          bus_error_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      WB_L: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      ir_q        <= '0;
      wait_q      <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      wait_q      <= wait_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
      instret_q   <= instret_d;
    end
  end

  // Control outputs decode the current state and latched IR; strobes are forced
  // low while reset is held so an interrupted instruction cannot commit.
  always_comb begin
    pcEn              = 1'b0;
    irEn              = 1'b0;
    regFileWe         = 1'b0;
    aluControl        = 4'b0000;
    alu_src_mux_sel   = 1'b0;
    busWe             = 1'b0;
    busRe             = 1'b0;
    rf_wd_src_mux_sel = 3'd0;
    mem_size          = 3'd0;
    branch            = 1'b0;
    jump              = 2'd0;
    case (state_q)
      FETCH: irEn = instr_valid;
      EX: begin
        alu_src_mux_sel = 1'b1;
        if (is_r) begin
          aluControl      = {ir_q[30], funct3};
          alu_src_mux_sel = 1'b0;
          regFileWe       = 1'b1;
          pcEn            = 1'b1;
        end else if (is_i) begin
          aluControl = (funct3 == 3'b001 || funct3 == 3'b101) ? {ir_q[30], funct3} : {1'b0, funct3};
          regFileWe  = 1'b1;
          pcEn       = 1'b1;
        end else if (is_lui || is_auipc) begin
          rf_wd_src_mux_sel = is_lui ? 3'd2 : 3'd3;
          regFileWe         = 1'b1;
          pcEn              = 1'b1;
        end else if (is_jal || is_jalr) begin
          rf_wd_src_mux_sel = 3'd4;
          jump              = is_jal ? 2'd1 : 2'd2;
          regFileWe         = 1'b1;
          pcEn              = 1'b1;
        end else if (is_br) begin
          aluControl      = {1'b0, funct3};
          alu_src_mux_sel = 1'b0;
          branch          = 1'b1;
          pcEn            = 1'b1;
        end
      end
      MEM_S: begin
        busWe    = 1'b1;
        mem_size = funct3;
        pcEn     = bus_ready;
      end
      MEM_L: begin
        busRe    = 1'b1;
        mem_size = funct3;
      end
      WB_L: begin
        regFileWe         = 1'b1;
        rf_wd_src_mux_sel = 3'd1;
        pcEn              = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pcEn      = 1'b0;
      irEn      = 1'b0;
      regFileWe = 1'b0;
      busWe     = 1'b0;
      busRe     = 1'b0;
      branch    = 1'b0;
    end
  end

  assign illegal_instr = illegal_q;
  assign bus_error     = bus_error_q;
  assign instret       = instret_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: a per-instruction transaction model predicts
// every output cycle of the main instance; a second instance covers EN_JUMP=0 / no timeout.
module tb_mc_control_unit;

  localparam int K_TERM = 0;
  localparam int K_BR   = 1;
  localparam int K_ST   = 2;
  localparam int K_LD   = 3;
  localparam int K_ILL  = 4;
  localparam int TMO    = 16;

  localparam logic [31:0] ADD_I  = 32'h002081B3;
  localparam logic [31:0] SRAI_I = 32'h4040D193;
  localparam logic [31:0] ADDI_I = 32'h40008093;
  localparam logic [31:0] LW_I   = 32'h0000A183;
  localparam logic [31:0] SW_I   = 32'h0020A023;
  localparam logic [31:0] BAD_I  = 32'h0000007F;
  localparam logic [31:0] JAL_I  = 32'h000000EF;

  typedef struct packed {
    logic       ir_en;
    logic       pc_en;
    logic       rf_we;
    logic [3:0] alu;
    logic       src;
    logic       bus_we;
    logic       bus_re;
    logic [2:0] wd;
    logic [2:0] msize;
    logic       br;
    logic [1:0] jmp;
    logic       ill;
    logic       berr;
    logic [3:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        iv = 1'b0, rdy = 1'b0;
  logic [31:0] instr_b = '0;
  logic        iv_b = 1'b0, rdy_b = 1'b0;

  logic       a_pcEn, a_irEn, a_we, a_src, a_bwe, a_bre, a_br, a_ill, a_berr;
  logic [3:0] a_alu, a_cnt;
  logic [2:0] a_wd, a_msize;
  logic [1:0] a_jmp;

  logic        b_pcEn, b_irEn, b_we, b_src, b_bwe, b_bre, b_br, b_ill, b_berr;
  logic [3:0]  b_alu;
  logic [2:0]  b_wd, b_msize;
  logic [1:0]  b_jmp;
  logic [31:0] b_cnt;

  mc_control_unit #(.MEM_TIMEOUT(TMO), .CNT_W(4), .EN_JUMP(1'b1)) dut_a (
    .clk(clk), .reset(reset), .instrCode(instr), .instr_valid(iv), .bus_ready(rdy),
    .pcEn(a_pcEn), .irEn(a_irEn), .regFileWe(a_we), .aluControl(a_alu),
    .alu_src_mux_sel(a_src), .busWe(a_bwe), .busRe(a_bre), .rf_wd_src_mux_sel(a_wd),
    .mem_size(a_msize), .branch(a_br), .jump(a_jmp), .illegal_instr(a_ill),
    .bus_error(a_berr), .instret(a_cnt)
  );

  mc_control_unit #(.MEM_TIMEOUT(0), .CNT_W(32), .EN_JUMP(1'b0)) dut_b (
    .clk(clk), .reset(reset), .instrCode(instr_b), .instr_valid(iv_b), .bus_ready(rdy_b),
    .pcEn(b_pcEn), .irEn(b_irEn), .regFileWe(b_we), .aluControl(b_alu),
    .alu_src_mux_sel(b_src), .busWe(b_bwe), .busRe(b_bre), .rf_wd_src_mux_sel(b_wd),
    .mem_size(b_msize), .branch(b_br), .jump(b_jmp), .illegal_instr(b_ill),
    .bus_error(b_berr), .instret(b_cnt)
  );

  int   total = 0;
  int   bad = 0;
  exp_t e;
  bit   exp_on = 1'b0;
  int   m_cnt = 0;
  bit   m_ill = 1'b0;
  bit   m_berr = 1'b0;
  int   run_cnt = 0, mon_lat = 0, bre_cnt = 0, bwe_cnt = 0, b_pc_cnt = 0;
  logic [3:0] mon_alu = '0;
  logic [2:0] mon_wd = '0;
  logic       mon_src = 1'b0, mon_we = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Compare process: every cycle the model owns, all outputs of dut_a must match it.
  always @(negedge clk) begin
    if (exp_on) begin
      checkOutput("irEn", 32'(a_irEn), 32'(e.ir_en));
      checkOutput("pcEn", 32'(a_pcEn), 32'(e.pc_en));
      checkOutput("regFileWe", 32'(a_we), 32'(e.rf_we));
      checkOutput("aluControl", 32'(a_alu), 32'(e.alu));
      checkOutput("alu_src", 32'(a_src), 32'(e.src));
      checkOutput("busWe", 32'(a_bwe), 32'(e.bus_we));
      checkOutput("busRe", 32'(a_bre), 32'(e.bus_re));
      checkOutput("rf_wd_src", 32'(a_wd), 32'(e.wd));
      checkOutput("mem_size", 32'(a_msize), 32'(e.msize));
      checkOutput("branch", 32'(a_br), 32'(e.br));
      checkOutput("jump", 32'(a_jmp), 32'(e.jmp));
      checkOutput("illegal_instr", 32'(a_ill), 32'(e.ill));
      checkOutput("bus_error", 32'(a_berr), 32'(e.berr));
      checkOutput("instret", 32'(a_cnt), 32'(e.cnt));
    end
  end

  // Observes the DUT itself to measure per-instruction latency and bus-strobe lengths.
  always @(negedge clk) begin
    if (a_irEn) begin
      run_cnt = 1;
      bre_cnt = 0;
      bwe_cnt = 0;
    end else begin
      run_cnt++;
    end
    if (a_bre) bre_cnt++;
    if (a_bwe) bwe_cnt++;
    if (a_pcEn) begin
      mon_lat = run_cnt;
      mon_alu = a_alu;
      mon_src = a_src;
      mon_wd  = a_wd;
      mon_we  = a_we;
    end
    if (b_pcEn) b_pc_cnt++;
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic exp_t base();
    exp_t x = '0;
    x.ill  = m_ill;
    x.berr = m_berr;
    x.cnt  = m_cnt[3:0];
    return x;
  endfunction

  function automatic int kindOf(input logic [31:0] c);
    case (c[6:0])
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: return K_TERM;
      7'b1100011: return K_BR;
      7'b0100011: return K_ST;
      7'b0000011: return K_LD;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic exp_t expEx(input logic [31:0] c);
    exp_t       x  = base();
    logic [2:0] f3 = c[14:12];
    x.src = 1'b1;
    case (c[6:0])
      7'b0110011: begin x.rf_we = 1; x.pc_en = 1; x.src = 0; x.alu = {c[30], f3}; end
      7'b0010011: begin
        x.rf_we = 1; x.pc_en = 1;
        x.alu = (f3 == 3'd1 || f3 == 3'd5) ? {c[30], f3} : {1'b0, f3};
      end
      7'b0110111: begin x.rf_we = 1; x.pc_en = 1; x.wd = 3'd2; end
      7'b0010111: begin x.rf_we = 1; x.pc_en = 1; x.wd = 3'd3; end
      7'b1101111: begin x.rf_we = 1; x.pc_en = 1; x.wd = 3'd4; x.jmp = 2'd1; end
      7'b1100111: begin x.rf_we = 1; x.pc_en = 1; x.wd = 3'd4; x.jmp = 2'd2; end
      7'b1100011: begin x.br = 1; x.pc_en = 1; x.src = 0; x.alu = {1'b0, f3}; end
      default: ;
    endcase
    return x;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] c = $urandom;
    case ($urandom_range(0, 8))
      0: c[6:0] = 7'b0110011;
      1: c[6:0] = 7'b0010011;
      2: c[6:0] = 7'b0110111;
      3: c[6:0] = 7'b0010111;
      4: c[6:0] = 7'b1100011;
      5: c[6:0] = 7'b1101111;
      6: c[6:0] = 7'b1100111;
      7: c[6:0] = 7'b0000011;
      default: c[6:0] = 7'b0100011;
    endcase
    return c;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] code, input logic r, input exp_t x);
    iv     = v;
    instr  = code;
    rdy    = r;
    e      = x;
    exp_on = 1'b1;
    cycle();
  endtask

  task automatic doReset();
    exp_on = 1'b0;
    reset  = 1'b1;
    iv = 1'b0; rdy = 1'b0; iv_b = 1'b0; rdy_b = 1'b0;
    cycle();
    cycle();
    reset    = 1'b0;
    m_cnt    = 0;
    m_ill    = 1'b0;
    m_berr   = 1'b0;
    b_pc_cnt = 0;
  endtask

  task automatic trapCycles();
    repeat (4) applyStimulus(rbit(), $urandom, rbit(), base());
  endtask

  // One instruction transaction: idle FETCH cycles, fetch, decode, then the tail its class needs.
  task automatic runInstr(input logic [31:0] code, input int waits, input int abort_at, input int idle);
    exp_t x;
    int   k = kindOf(code);
    for (int i = 0; i < idle; i++) applyStimulus(1'b0, $urandom, rbit(), base());
    x = base(); x.ir_en = 1'b1;
    applyStimulus(1'b1, code, rbit(), x);
    applyStimulus(rbit(), $urandom, rbit(), base());
    if (k == K_ILL) begin
      m_ill = 1'b1;
      trapCycles();
      return;
    end
    applyStimulus(rbit(), $urandom, rbit(), expEx(code));
    if (k == K_TERM || k == K_BR) begin
      m_cnt = (m_cnt + 1) % 16;
      return;
    end
    for (int w = 0; ; w++) begin
      logic r = (w == waits);
      if (w == abort_at) begin
        exp_on = 1'b0;
        reset = 1'b1; iv = 1'b0; rdy = 1'b0;
        @(negedge clk);
        checkOutput("abort_pcEn", 32'(a_pcEn), 32'd0);
        checkOutput("abort_regFileWe", 32'(a_we), 32'd0);
        checkOutput("abort_busRe", 32'(a_bre), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_cnt = 0; m_ill = 1'b0; m_berr = 1'b0;
        return;
      end
      x = base();
      x.msize = code[14:12];
      if (k == K_ST) begin
        x.bus_we = 1'b1;
        x.pc_en  = r;
      end else begin
        x.bus_re = 1'b1;
      end
      applyStimulus(rbit(), $urandom, r, x);
      if (r) break;
      if (w + 1 == TMO) begin
        m_berr = 1'b1;
        trapCycles();
        return;
      end
    end
    if (k == K_LD) begin
      x = base(); x.rf_we = 1'b1; x.wd = 3'd1; x.pc_en = 1'b1;
      applyStimulus(rbit(), $urandom, rbit(), x);
    end
    m_cnt = (m_cnt + 1) % 16;
  endtask

  initial begin
    logic [3:0] pre;
    doReset();
    checkOutput("rst_instret", 32'(a_cnt), 32'd0);
    checkOutput("rst_illegal", 32'(a_ill), 32'd0);
    checkOutput("rst_bus_error", 32'(a_berr), 32'd0);

    runInstr(ADD_I, 0, -1, 0);
    checkOutput("add_latency", 32'(mon_lat), 32'd3);
    checkOutput("add_alu", 32'(mon_alu), 32'h0);
    checkOutput("add_we", 32'(mon_we), 32'd1);
    checkOutput("add_instret", 32'(a_cnt), 32'd1);

    runInstr(SRAI_I, 0, -1, 1);
    checkOutput("srai_alu", 32'(mon_alu), 32'hD);
    checkOutput("srai_src", 32'(mon_src), 32'd1);
    runInstr(ADDI_I, 0, -1, 0);
    checkOutput("addi_b30_alu", 32'(mon_alu), 32'h0);

    runInstr(LW_I, 3, -1, 0);
    checkOutput("lw_latency", 32'(mon_lat), 32'd8);
    checkOutput("lw_busre_cycles", 32'(bre_cnt), 32'd4);
    checkOutput("lw_wd_src", 32'(mon_wd), 32'd1);
    runInstr(SW_I, 0, -1, 0);
    checkOutput("sw_latency", 32'(mon_lat), 32'd4);
    runInstr(SW_I, TMO - 1, -1, 0);
    checkOutput("sw_last_wait_latency", 32'(mon_lat), 32'd19);
    checkOutput("sw_last_wait_berr", 32'(a_berr), 32'd0);

    repeat (40) runInstr(randInstr(), $urandom_range(0, 6), -1, $urandom_range(0, 2));

    pre = a_cnt;
    runInstr(SW_I, 1000, -1, 0);
    checkOutput("timeout_berr", 32'(a_berr), 32'd1);
    checkOutput("timeout_buswe_cycles", 32'(bwe_cnt), 32'd16);
    checkOutput("timeout_instret", 32'(a_cnt), 32'(pre));

    doReset();
    runInstr(ADD_I, 0, -1, 1);
    checkOutput("post_trap_latency", 32'(mon_lat), 32'd3);
    runInstr(BAD_I, 0, -1, 0);
    checkOutput("illegal_flag", 32'(a_ill), 32'd1);

    doReset();
    checkOutput("illegal_cleared", 32'(a_ill), 32'd0);
    runInstr(ADD_I, 0, -1, 0);
    runInstr(LW_I, 10, 2, 0);
    checkOutput("abort_instret", 32'(a_cnt), 32'd0);
    runInstr(ADD_I, 0, -1, 1);

    doReset();
    repeat (15) runInstr(randInstr(), 0, -1, 0);
    checkOutput("instret_max", 32'(a_cnt), 32'd15);
    runInstr(ADD_I, 0, -1, 0);
    checkOutput("instret_wrap", 32'(a_cnt), 32'd0);

    doReset();
    iv_b = 1'b1; instr_b = JAL_I;
    cycle();
    iv_b = 1'b0; instr_b = $urandom;
    cycle();
    cycle();
    iv_b = 1'b1;
    #1;
    checkOutput("b_jal_illegal", 32'(b_ill), 32'd1);
    checkOutput("b_trap_irEn", 32'(b_irEn), 32'd0);
    checkOutput("b_trap_strobes", 32'({b_bwe, b_br, b_src, b_jmp, b_alu}), 32'd0);
    checkOutput("b_jal_no_pcEn", 32'(b_pc_cnt), 32'd0);
    iv_b = 1'b0;

    doReset();
    iv_b = 1'b1; instr_b = LW_I;
    cycle();
    iv_b = 1'b0;
    cycle();
    cycle();
    repeat (40) cycle();
    checkOutput("b_no_timeout_busRe", 32'(b_bre), 32'd1);
    checkOutput("b_no_timeout_berr", 32'(b_berr), 32'd0);
    checkOutput("b_mem_size", 32'(b_msize), 32'd2);
    rdy_b = 1'b1;
    cycle();
    rdy_b = 1'b0;
    checkOutput("b_wb_we", 32'(b_we), 32'd1);
    checkOutput("b_wb_src", 32'(b_wd), 32'd1);
    cycle();
    checkOutput("b_instret", b_cnt, 32'd1);
    checkOutput("b_pc_pulses", 32'(b_pc_cnt), 32'd1);

    exp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
